// File: rtl/tx_skp_inserter.sv
// TX SKP ordered-set scheduler: merges upstream symbols with periodic COM+SKP sets.
// Optional SKP_STATS_EN adds the skp_total COM counter port.
module tx_skp_inserter #(
    parameter int DATA_WIDTH   = 8,
    parameter int SKP_INTERVAL = 1180,
    parameter int SKP_COUNT    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_k,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_k,
    output logic                  skp_inserted,
    output logic                  skp_missed
`ifdef SKP_STATS_EN
    ,
    output logic [15:0]           skp_total
`endif
);

    localparam int CW = (SKP_INTERVAL > 1) ? $clog2(SKP_INTERVAL) : 1;

    localparam logic [DATA_WIDTH-1:0] SYM_COM  = DATA_WIDTH'(8'hBC);
    localparam logic [DATA_WIDTH-1:0] SYM_SKP  = DATA_WIDTH'(8'h1C);
    localparam logic [DATA_WIDTH-1:0] SYM_STP  = DATA_WIDTH'(8'hFB);
    localparam logic [DATA_WIDTH-1:0] SYM_SDP  = DATA_WIDTH'(8'h5C);
    localparam logic [DATA_WIDTH-1:0] SYM_END  = DATA_WIDTH'(8'hFD);
    localparam logic [DATA_WIDTH-1:0] SYM_EDB  = DATA_WIDTH'(8'hFE);
    localparam logic [DATA_WIDTH-1:0] SYM_IDLE = '0;

    localparam logic [CW-1:0] IVL_LAST = CW'(SKP_INTERVAL - 1);
    localparam logic [1:0]    SKP_LAST = 2'(SKP_COUNT - 1);

    typedef enum logic [0:0] {
        ST_DATA,
        ST_SKP
    } state_t;

    state_t        state;
    logic [CW-1:0] ivl_cnt;
    logic [1:0]    pending;
    logic [1:0]    skp_idx;
    logic          in_pkt;

    logic sched;
    logic com_go;
    logic accept;
    logic pkt_open;
    logic pkt_close;

    assign sched    = (ivl_cnt == IVL_LAST);
    assign com_go   = (state == ST_DATA) && (pending != 2'd0) && !in_pkt;
    assign in_ready = !rst && (state == ST_DATA)
                      && !((pending != 2'd0) && !in_pkt);
    assign accept   = in_valid && in_ready;

    assign pkt_open  = accept && in_k
                       && ((in_data == SYM_STP) || (in_data == SYM_SDP));
    assign pkt_close = accept && in_k
                       && ((in_data == SYM_END) || (in_data == SYM_EDB));

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_DATA;
            ivl_cnt      <= '0;
            pending      <= 2'd0;
            skp_idx      <= 2'd0;
            in_pkt       <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_k        <= 1'b0;
            skp_inserted <= 1'b0;
            skp_missed   <= 1'b0;
        end else begin
            out_valid    <= 1'b1;
            skp_inserted <= com_go;
            skp_missed   <= sched && !com_go && (pending == 2'd2);
            ivl_cnt      <= sched ? '0 : ivl_cnt + 1'b1;

            // a schedule event coinciding with a COM decision nets to zero
            case ({sched, com_go})
                2'b10:   if (pending != 2'd2) pending <= pending + 2'd1;
                2'b01:   pending <= pending - 2'd1;
                default: pending <= pending;
            endcase

            unique case (state)
                ST_DATA: begin
                    if (com_go) begin
                        out_data <= SYM_COM;
                        out_k    <= 1'b1;
                        skp_idx  <= 2'd0;
                        state    <= ST_SKP;
                    end else if (accept) begin
                        out_data <= in_data;
                        out_k    <= in_k;
                        if (pkt_open) in_pkt <= 1'b1;
                        else if (pkt_close) in_pkt <= 1'b0;
                    end else begin
                        out_data <= SYM_IDLE;
                        out_k    <= 1'b0;
                    end
                end
                ST_SKP: begin
                    out_data <= SYM_SKP;
                    out_k    <= 1'b1;
                    if (skp_idx == SKP_LAST) state <= ST_DATA;
                    else skp_idx <= skp_idx + 2'd1;
                end
                default: state <= ST_DATA;
            endcase
        end
    end

`ifdef SKP_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) skp_total <= 16'd0;
        else if (com_go && (skp_total != 16'hFFFF)) skp_total <= skp_total + 16'd1;
    end
`endif

endmodule

// File: tb/tb_tx_skp_inserter.sv
// Directed bench for tx_skp_inserter (SKP_INTERVAL=16, SKP_COUNT=3).
// Table vectors for reset/idle scheduling plus packet, backpressure and reset sequences.
module tb_tx_skp_inserter;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_k;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_k;
    logic       skp_inserted;
    logic       skp_missed;
`ifdef SKP_STATS_EN
    logic [15:0] skp_total;
`endif

    always #5 clk = ~clk;

    tx_skp_inserter #(
        .DATA_WIDTH  (8),
        .SKP_INTERVAL(16),
        .SKP_COUNT   (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_k        (in_k),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_k       (out_k),
        .skp_inserted(skp_inserted),
        .skp_missed  (skp_missed)
`ifdef SKP_STATS_EN
        ,
        .skp_total   (skp_total)
`endif
    );

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    typedef struct {
        logic       rst;
        logic       iv;
        logic [7:0] id;
        logic       ik;
        logic       rdy;
        logic       ov;
        logic [7:0] od;
        logic       ok;
        logic       ins;
    } vec_t;

    vec_t vt[$];

    logic [8:0] tx_q[$];
    logic [8:0] exp_q[$];
    logic [8:0] got_q[$];
    logic       ins_q[$];
    logic       miss_q[$];
    logic       rdy_q[$];
    int         consumed;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic build_table();
        vec_t v;
        int   ph;
        logic inset;
        for (int i = 0; i < 3; i++) begin
            v = '{1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
            vt.push_back(v);
        end
        // SKP sets at output cycles 17..20 and 33..36 after release
        for (int n = 1; n <= 40; n++) begin
            ph    = (n - 1) % 16;
            inset = (n > 16) && (ph < 4);
            v.rst = 1'b0;
            v.iv  = 1'b0;
            v.id  = 8'h00;
            v.ik  = 1'b0;
            v.rdy = !inset;
            v.ov  = 1'b1;
            v.od  = inset ? ((ph == 0) ? 8'hBC : 8'h1C) : 8'h00;
            v.ok  = inset;
            v.ins = inset && (ph == 0);
            vt.push_back(v);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_k     = 1'b0;
        repeat (3) step();
        rst = 1'b0;
    endtask

    task automatic push_set();
        exp_q.push_back(9'h1BC);
        repeat (3) exp_q.push_back(9'h11C);
    endtask

    task automatic run_stream(input int ncyc);
        int   idx;
        logic r;
        idx = 0;
        got_q.delete();
        ins_q.delete();
        miss_q.delete();
        rdy_q.delete();
        for (int n = 0; n < ncyc; n++) begin
            in_valid = (idx < tx_q.size());
            if (in_valid) {in_k, in_data} = tx_q[idx];
            else begin
                in_k    = 1'b0;
                in_data = 8'h00;
            end
            #1;
            r = in_ready;
            rdy_q.push_back(r);
            @(posedge clk);
            #1;
            chk($sformatf("out_valid c%0d", n + 1), out_valid, 1);
            got_q.push_back({out_k, out_data});
            ins_q.push_back(skp_inserted);
            miss_q.push_back(skp_missed);
            if (in_valid && r) idx++;
        end
        in_valid = 1'b0;
        consumed = idx;
    endtask

    task automatic check_stream(input string name);
        chk({name, " len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk($sformatf("%s sym c%0d", name, i + 1), got_q[i], exp_q[i]);
            chk($sformatf("%s ins c%0d", name, i + 1), ins_q[i],
                (exp_q[i] == 9'h1BC) ? 1 : 0);
        end
    endtask

    function automatic int count_miss();
        int c;
        c = 0;
        foreach (miss_q[i]) if (miss_q[i]) c++;
        return c;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_k     = 1'b0;

        // reset and idle periodic scheduling
        build_table();
        foreach (vt[i]) begin
            rst      = vt[i].rst;
            in_valid = vt[i].iv;
            in_data  = vt[i].id;
            in_k     = vt[i].ik;
            #1;
            chk($sformatf("vec%0d in_ready", i), in_ready, vt[i].rdy);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d out_valid", i), out_valid, vt[i].ov);
            chk($sformatf("vec%0d out_data", i), out_data, vt[i].od);
            chk($sformatf("vec%0d out_k", i), out_k, vt[i].ok);
            chk($sformatf("vec%0d skp_inserted", i), skp_inserted, vt[i].ins);
            chk($sformatf("vec%0d skp_missed", i), skp_missed, 0);
        end

        // deferral: 30-byte packet straddling expiries at cycles 16 and 32
        do_reset();
        tx_q.delete();
        exp_q.delete();
        tx_q.push_back(9'h1FB);
        for (int b = 1; b <= 30; b++) tx_q.push_back(9'(b));
        tx_q.push_back(9'h1FD);
        foreach (tx_q[i]) exp_q.push_back(tx_q[i]);
        push_set();
        push_set();
        repeat (4) exp_q.push_back(9'h000);
        run_stream(44);
        check_stream("defer");
        chk("defer consumed", consumed, tx_q.size());
        chk("defer missed", count_miss(), 0);

        // 40 payload: two deferred sets, plus one from the cycle-48 event
        do_reset();
        tx_q.delete();
        exp_q.delete();
        tx_q.push_back(9'h1FB);
        for (int b = 1; b <= 40; b++) tx_q.push_back(9'(b));
        tx_q.push_back(9'h1FD);
        foreach (tx_q[i]) exp_q.push_back(tx_q[i]);
        push_set();
        push_set();
        push_set();
        repeat (4) exp_q.push_back(9'h000);
        run_stream(58);
        check_stream("sat40");
        chk("sat40 consumed", consumed, tx_q.size());
        chk("sat40 missed", count_miss(), 0);

        // 50 payload: third expiry at cycle 48 is dropped
        do_reset();
        tx_q.delete();
        exp_q.delete();
        tx_q.push_back(9'h1FB);
        for (int b = 1; b <= 50; b++) tx_q.push_back(9'(b));
        tx_q.push_back(9'h1FD);
        foreach (tx_q[i]) exp_q.push_back(tx_q[i]);
        push_set();
        push_set();
        repeat (4) exp_q.push_back(9'h000);
        push_set();
        run_stream(68);
        check_stream("sat50");
        chk("sat50 consumed", consumed, tx_q.size());
        chk("sat50 missed count", count_miss(), 1);
        chk("sat50 missed at c48", miss_q[47], 1);

        // backpressure with unframed data
        do_reset();
        tx_q.delete();
        exp_q.delete();
        for (int b = 0; b < 64; b++) tx_q.push_back(9'(8'h40 + b));
        begin
            int d;
            int ph;
            d = 8'h40;
            for (int n = 1; n <= 48; n++) begin
                ph = (n - 1) % 16;
                if (n > 16 && ph < 4) exp_q.push_back((ph == 0) ? 9'h1BC : 9'h11C);
                else begin
                    exp_q.push_back(9'(d));
                    d++;
                end
            end
        end
        run_stream(48);
        check_stream("bp");
        for (int n = 1; n <= 48; n++)
            chk($sformatf("bp in_ready c%0d", n), rdy_q[n-1],
                (n > 16 && ((n - 1) % 16) < 4) ? 0 : 1);

        // reset asserted while the second SKP is on the output
        do_reset();
        repeat (19) step();
        chk("mid out_data", out_data, 8'h1C);
        chk("mid out_k", out_k, 1);
`ifdef SKP_STATS_EN
        chk("mid skp_total", skp_total, 1);
`endif
        rst = 1'b1;
        #1;
        chk("mid rst in_ready", in_ready, 0);
        step();
        chk("mid rst out_valid", out_valid, 0);
        chk("mid rst out_data", out_data, 8'h00);
        chk("mid rst out_k", out_k, 0);
        chk("mid rst skp_inserted", skp_inserted, 0);
`ifdef SKP_STATS_EN
        chk("mid rst skp_total", skp_total, 0);
`endif
        rst = 1'b0;
        for (int n = 1; n <= 16; n++) begin
            step();
            chk($sformatf("post c%0d sym", n), {out_k, out_data}, 9'h000);
        end
        step();
        chk("post c17 sym", {out_k, out_data}, 9'h1BC);
        chk("post c17 ins", skp_inserted, 1);
`ifdef SKP_STATS_EN
        chk("post c17 skp_total", skp_total, 1);
`endif
        step();
        chk("post c18 sym", {out_k, out_data}, 9'h11C);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
